// File: rtl/msk_ct_word_serializer.sv
// Purpose : capture one masked 128-bit ciphertext (shbus, d shares) and stream it out as four 32-bit masked words.
// Latency : first word visible the cycle after the load handshake; a block drains in 4 cycles, back-to-back with no bubble.
// Backpressure: out_valid/out_ready hold rule on the output; in_ready only while empty or on the last-word pop.
//
// Ports:
//   clk        system clock, all state on rising edge
//   rst        synchronous reset, active-low
//   in_valid   masked ciphertext available (from core cipher_valid)
//   in_ready   buffer can accept (to core out_ready)
//   sh_in      masked ciphertext, shbus encoding: bit i shares at [i*d +: d]
//   out_valid  sh_word holds a valid word
//   out_ready  consumer accepts sh_word this cycle
//   sh_word    masked word j = sh_in[j*32*d +: 32*d], shbus encoding
//   out_idx    index of the current word (0..3)
//   out_last   high with out_valid on word 3
//
// Shares are only routed, never combined: word select is a mux on the registered counter.
module msk_ct_word_serializer #(
    parameter int d           = 2,
    parameter bit CLEAR_EMPTY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [128*d-1:0]  sh_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*d-1:0]   sh_word,
    output logic [1:0]        out_idx,
    output logic              out_last
);

    localparam int WW = 32 * d;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [3:0][WW-1:0]     blk_q, blk_d;

    logic full;
    logic pop;
    logic last_pop;
    logic load;

    assign full      = (state_q == SEND);

    // Outputs are forced to zero while reset is asserted, even before the
    // clock edge that clears the registers.
    assign out_valid = rst & full;
    assign out_last  = out_valid & (cnt_q == 2'd3);
    assign out_idx   = rst ? cnt_q : 2'd0;
    assign sh_word   = rst ? blk_q[cnt_q] : '0;

    assign pop       = out_valid & out_ready;
    assign last_pop  = pop & (cnt_q == 2'd3);

    // A new block may load in the same cycle the last word leaves, so a
    // continuous source sees no idle cycle between blocks.
    assign in_ready  = rst & (~full | last_pop);
    assign load      = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        unique case (state_q)
            EMPTY: begin
                if (load) begin
                    blk_d   = sh_in;
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (load) begin
                    // only reachable together with the last pop: load wins
                    blk_d   = sh_in;
                    cnt_d   = 2'd0;
                    state_d = SEND;
                end else if (pop) begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = EMPTY;
                        if (CLEAR_EMPTY) begin
                            // drop the consumed shares rather than leave them resident
                            blk_d = '0;
                        end
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            cnt_q   <= 2'd0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

endmodule

// File: tb/tb_msk_ct_word_serializer.sv
// Purpose : self-checking bench for msk_ct_word_serializer (d=2), scoreboard of expected words.
// Latency : expected words are queued on the load handshake and compared while presented.
// Backpressure: directed and random out_ready / in_valid patterns.
module tb_msk_ct_word_serializer;

    localparam int D  = 2;
    localparam int W  = 32 * D;
    localparam int BW = 128 * D;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [BW-1:0]  sh_in;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   sh_word;
    logic [1:0]     out_idx;
    logic           out_last;

    logic           b_in_ready;
    logic           b_out_valid;
    logic [W-1:0]   b_sh_word;
    logic [1:0]     b_out_idx;
    logic           b_out_last;

    msk_ct_word_serializer #(.d(D), .CLEAR_EMPTY(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sh_in(sh_in),
        .out_valid(out_valid), .out_ready(out_ready), .sh_word(sh_word),
        .out_idx(out_idx), .out_last(out_last)
    );

    msk_ct_word_serializer #(.d(D), .CLEAR_EMPTY(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .sh_in(sh_in),
        .out_valid(b_out_valid), .out_ready(out_ready), .sh_word(b_sh_word),
        .out_idx(b_out_idx), .out_last(b_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] word;
        logic [1:0]   idx;
        logic [31:0]  plain;
    } exp_t;

    exp_t         q[$];
    int           tests = 0;
    int           fails = 0;
    int           pops  = 0;
    int           loads = 0;
    int           vld_cycles = 0;
    logic [127:0] cur_c;
    logic [127:0] cur_m;

    function automatic logic [BW-1:0] shbus(input logic [127:0] s0, input logic [127:0] s1);
        logic [BW-1:0] r;
        for (int i = 0; i < 128; i++) begin
            r[i*2]     = s0[i];
            r[i*2 + 1] = s1[i];
        end
        return r;
    endfunction

    function automatic logic [31:0] recomb(input logic [W-1:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = w[i*2] ^ w[i*2 + 1];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_block(input logic [127:0] c, input logic [127:0] m);
        cur_c = c;
        cur_m = m;
        sh_in = shbus(c ^ m, m);
    endtask

    task automatic push_block();
        logic [BW-1:0] sh;
        exp_t e;
        sh = shbus(cur_c ^ cur_m, cur_m);
        for (int j = 0; j < 4; j++) begin
            e.word  = sh[j*W +: W];
            e.idx   = 2'(j);
            e.plain = cur_c[j*32 +: 32];
            q.push_back(e);
        end
    endtask

    // Called at the falling edge with inputs already driven; checks the
    // presented cycle against the model, then advances one clock.
    task automatic tick();
        logic exp_vld;
        logic exp_rdy;
        #1;
        if (!rst) begin
            chk("rst_in_ready",  {255'd0, in_ready},  '0);
            chk("rst_out_valid", {255'd0, out_valid}, '0);
            chk("rst_out_last",  {255'd0, out_last},  '0);
            chk("rst_out_idx",   {254'd0, out_idx},   '0);
            chk("rst_sh_word",   {192'd0, sh_word},   '0);
            q.delete();
        end else begin
            exp_vld = (q.size() != 0);
            if (!exp_vld) exp_rdy = 1'b1;
            else          exp_rdy = out_ready && (q[0].idx == 2'd3);
            chk("in_ready",  {255'd0, in_ready},  {255'd0, exp_rdy});
            chk("out_valid", {255'd0, out_valid}, {255'd0, exp_vld});
            if (out_valid) vld_cycles++;
            if (exp_vld) begin
                chk("sh_word",  {192'd0, sh_word},         {192'd0, q[0].word});
                chk("out_idx",  {254'd0, out_idx},         {254'd0, q[0].idx});
                chk("out_last", {255'd0, out_last},        {255'd0, (q[0].idx == 2'd3)});
                chk("recomb",   {224'd0, recomb(sh_word)}, {224'd0, q[0].plain});
                if (out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
            if (in_valid && exp_rdy) begin
                push_block();
                loads++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0]  kat_words [4];
        logic [127:0] mask_a5;
        logic [127:0] c6;
        int p0, v0, l0, guard, target;

        kat_words[0] = 32'hd8e0c469;
        kat_words[1] = 32'h30047b6a;
        kat_words[2] = 32'h80b7cdd8;
        kat_words[3] = 32'h5ac5b470;
        mask_a5 = {16{8'hA5}};

        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sh_in     = '0;
        cur_c     = '0;
        cur_m     = '0;
        @(negedge clk);

        // reset state, then the first cycle after release
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: known-answer block, consumer always ready
        set_block(128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469, mask_a5);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        v0 = vld_cycles;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t1_kat_word", {224'd0, recomb(sh_word)}, {224'd0, kat_words[k]});
            tick();
        end
        tick();
        tick();
        chk("t1_vld_cycles", BW'(vld_cycles - v0), BW'(4));

        // 2: stalls hold word and index; exactly four pops in order
        set_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        p0 = pops;
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b0; tick();
        out_ready = 1'b1; tick();
        out_ready = 1'b1; tick();
        chk("t2_pops",  BW'(pops - p0), BW'(4));
        chk("t2_drain", BW'(q.size()), '0);

        // 3: two blocks back to back, 8 words in 8 consecutive cycles
        set_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        in_valid  = 1'b1;
        out_ready = 1'b1;
        l0 = loads;
        tick();
        set_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        v0 = vld_cycles;
        for (int k = 0; k < 4; k++) tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("t3_vld_cycles", BW'(vld_cycles - v0), BW'(8));
        chk("t3_loads",      BW'(loads - l0),      BW'(2));
        tick();
        chk("t3_drain",      BW'(q.size()),        '0);

        // 4: reset mid-block discards the remaining words
        set_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        v0 = vld_cycles;
        for (int k = 0; k < 6; k++) tick();
        chk("t4_no_stale_words", BW'(vld_cycles - v0), '0);

        // 5: buffer cleared (CLEAR_EMPTY=1) or retained (CLEAR_EMPTY=0) after last pop
        c6 = {$urandom, $urandom, $urandom, $urandom};
        set_block(c6, {$urandom, $urandom, $urandom, $urandom});
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        #1;
        chk("t5_clear_buf",   BW'(dut_a.blk_q),         '0);
        chk("t5_retain_buf",  BW'(dut_b.blk_q),         shbus(c6 ^ cur_m, cur_m));
        chk("t5_b_out_valid", {255'd0, b_out_valid},    '0);
        chk("t5_b_in_ready",  {255'd0, b_in_ready},     {255'd0, 1'b1});

        // 6: random back-pressure and random source
        l0 = loads;
        p0 = pops;
        target = 300;
        guard = 0;
        set_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        while ((loads - l0) < target && guard < 20000) begin
            int lb;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            lb = loads;
            tick();
            if (loads != lb)
                set_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
            guard++;
        end
        chk("t6_budget", {255'd0, (guard < 20000)}, {255'd0, 1'b1});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("t6_drain", BW'(q.size()),    '0);
        chk("t6_pops",  BW'(pops - p0),   BW'(4 * (loads - l0)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
